// File: rtl/avs_bridge_pkg.sv
// Shared definitions for the Avalon-MM read bridge: FSM states, data width,
// default CPU-side byte-address width.
package avs_bridge_pkg;

    localparam int unsigned ADDR_W_DEF = 18;
    localparam int unsigned DATA_W     = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DREQ   = 3'd1,
        DWAIT  = 3'd2,
        RESP   = 3'd3,
        PFREQ  = 3'd4,
        PFWAIT = 3'd5
    } bridge_state_t;

endpackage

// File: rtl/avs_pf_buffer.sv
// One-word prefetch buffer: holds a word address tag, its data and a valid bit.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   flush        clears valid on this edge and masks the hit output at once
//   wr_en        capture wr_tag/wr_data and set valid (flush wins)
//   lookup_tag   word address to compare
//   hit_c        combinational hit (valid, tag match, no flush)
//   data         buffered word
module avs_pf_buffer
    import avs_bridge_pkg::*;
#(
    parameter int unsigned TAG_W = ADDR_W_DEF - 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [TAG_W-1:0]  lookup_tag,
    output logic              hit_c,
    output logic [DATA_W-1:0] data
);

    logic             valid;
    logic [TAG_W-1:0] tag;

    // Buffer storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else begin
            if (flush) begin
                valid <= 1'b0;
            end else if (wr_en) begin
                valid <= 1'b1;
            end
            if (wr_en) begin
                tag  <= wr_tag;
                data <= wr_data;
            end
        end
    end

    // A flush in the lookup cycle forces a miss
    assign hit_c = valid && (tag == lookup_tag) && !flush;

endmodule

// File: rtl/avs_read_bridge.sv
// CPU read port to Avalon-MM pipelined-read master bridge with an optional
// one-word next-address prefetch. At most one Avalon read is outstanding.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   rv_valid/rv_addr               CPU read request (held until rv_ready)
//   rv_ready/rv_rdata              one-cycle response pulse and held read data
//   pf_flush                       invalidate the prefetch buffer
//   avm_address/avm_read           Avalon command (word address)
//   avm_waitrequest                Avalon stall
//   avm_readdata/avm_readdatavalid Avalon pipelined response
module avs_read_bridge
    import avs_bridge_pkg::*;
#(
    parameter bit          PREFETCH_EN = 1'b1,
    parameter int unsigned ADDR_W      = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rv_valid,
    output logic              rv_ready,
    input  logic [ADDR_W-1:0] rv_addr,
    output logic [DATA_W-1:0] rv_rdata,
    input  logic              pf_flush,
    output logic [ADDR_W-3:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid
);

    localparam int unsigned TAG_W = ADDR_W - 2;

    bridge_state_t     state, state_nxt;
    logic [TAG_W-1:0]  req_tag, req_tag_nxt;
    logic [TAG_W-1:0]  avm_address_nxt;
    logic [DATA_W-1:0] rv_rdata_nxt;
    logic              rv_ready_nxt;
    logic              avm_read_nxt;
    // Sticky: the in-flight Avalon response must be thrown away
    logic              drop, drop_nxt;
    logic              pf_hit_c;
    logic              pf_wr_c;
    logic [DATA_W-1:0] pf_data;
    logic [TAG_W-1:0]  rv_tag_c;
    logic              unused_addr_lsb;

    assign rv_tag_c        = rv_addr[ADDR_W-1:2];
    assign unused_addr_lsb = ^rv_addr[1:0];

    avs_pf_buffer #(
        .TAG_W (TAG_W)
    ) u_pf_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (pf_flush),
        .wr_en      (pf_wr_c),
        .wr_tag     (avm_address),
        .wr_data    (avm_readdata),
        .lookup_tag (rv_tag_c),
        .hit_c      (pf_hit_c),
        .data       (pf_data)
    );

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            req_tag     <= '0;
            drop        <= 1'b0;
            rv_ready    <= 1'b0;
            rv_rdata    <= '0;
            avm_read    <= 1'b0;
            avm_address <= '0;
        end else begin
            state       <= state_nxt;
            req_tag     <= req_tag_nxt;
            drop        <= drop_nxt;
            rv_ready    <= rv_ready_nxt;
            rv_rdata    <= rv_rdata_nxt;
            avm_read    <= avm_read_nxt;
            avm_address <= avm_address_nxt;
        end
    end

    // Next state and next output values
    always_comb begin
        state_nxt       = state;
        req_tag_nxt     = req_tag;
        drop_nxt        = drop;
        rv_ready_nxt    = 1'b0;
        rv_rdata_nxt    = rv_rdata;
        avm_read_nxt    = avm_read;
        avm_address_nxt = avm_address;
        pf_wr_c         = 1'b0;

        case (state)
            IDLE: begin
                if (rv_valid) begin
                    req_tag_nxt = rv_tag_c;
                    if (pf_hit_c) begin
                        state_nxt    = RESP;
                        rv_ready_nxt = 1'b1;
                        rv_rdata_nxt = pf_data;
                    end else begin
                        state_nxt       = DREQ;
                        avm_read_nxt    = 1'b1;
                        avm_address_nxt = rv_tag_c;
                        drop_nxt        = 1'b0;
                    end
                end
            end

            DREQ: begin
                if (!rv_valid) begin
                    drop_nxt = 1'b1;
                end
                if (!avm_waitrequest) begin
                    avm_read_nxt = 1'b0;
                    state_nxt    = DWAIT;
                end
            end

            DWAIT: begin
                if (avm_readdatavalid) begin
                    if (drop || !rv_valid) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt    = RESP;
                        rv_ready_nxt = 1'b1;
                        rv_rdata_nxt = avm_readdata;
                    end
                end else if (!rv_valid) begin
                    drop_nxt = 1'b1;
                end
            end

            RESP: begin
                if (PREFETCH_EN) begin
                    state_nxt       = PFREQ;
                    avm_read_nxt    = 1'b1;
                    avm_address_nxt = req_tag + TAG_W'(1);
                    drop_nxt        = 1'b0;
                end else begin
                    state_nxt = IDLE;
                end
            end

            PFREQ: begin
                if (pf_flush) begin
                    drop_nxt = 1'b1;
                end
                if (!avm_waitrequest) begin
                    avm_read_nxt = 1'b0;
                    state_nxt    = PFWAIT;
                end
            end

            PFWAIT: begin
                if (avm_readdatavalid) begin
                    pf_wr_c   = !(drop || pf_flush);
                    state_nxt = IDLE;
                end else if (pf_flush) begin
                    drop_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt    = IDLE;
                avm_read_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_avs_read_bridge.sv
// Scoreboarded bench for avs_read_bridge with a behavioural Avalon slave.
module tb_avs_read_bridge;

    localparam int unsigned ADDR_W = 18;
    localparam int unsigned TAG_W  = ADDR_W - 2;

    logic              clk;
    logic              rst_n;
    logic              rv_valid;
    logic              rv_ready;
    logic [ADDR_W-1:0] rv_addr;
    logic [31:0]       rv_rdata;
    logic              pf_flush;
    logic [TAG_W-1:0]  avm_address;
    logic              avm_read;
    logic              avm_waitrequest;
    logic [31:0]       avm_readdata;
    logic              avm_readdatavalid;

    avs_read_bridge #(
        .PREFETCH_EN (1'b1),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rv_valid          (rv_valid),
        .rv_ready          (rv_ready),
        .rv_addr           (rv_addr),
        .rv_rdata          (rv_rdata),
        .pf_flush          (pf_flush),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [TAG_W-1:0] a);
        if (a == 16'h0040) return 32'hCAFE0001;
        if (a == 16'h0041) return 32'h12345678;
        return {16'hBEEF ^ a, a};
    endfunction

    // Avalon slave model
    typedef struct {
        int          due;
        logic [31:0] d;
    } resp_t;

    resp_t            resp_q[$];
    int               cyc         = 0;
    int               lat         = 2;
    int               stall_cfg   = 0;
    int               stall_left  = 0;
    int               outstanding = 0;
    int               cmd_count   = 0;
    int               hi_cnt      = 0;
    int               last_hi     = 0;
    int               unstable    = 0;
    logic             prev_rd     = 1'b0;
    logic [TAG_W-1:0] prev_a      = '0;
    logic [TAG_W-1:0] last_addr   = '0;

    assign avm_waitrequest = (stall_left != 0);

    initial begin
        avm_readdata      = '0;
        avm_readdatavalid = 1'b0;
    end

    always @(posedge clk) begin
        logic             acc;
        logic             rd;
        logic [TAG_W-1:0] a;
        resp_t            r;
        acc = avm_read && !avm_waitrequest;
        rd  = avm_read;
        a   = avm_address;
        #1;
        cyc++;
        if (rd) begin
            if (prev_rd && (a != prev_a)) unstable++;
            hi_cnt++;
        end
        prev_rd = rd;
        prev_a  = a;
        if (acc) begin
            check("one_outstanding", 32'(outstanding), 32'd0);
            outstanding++;
            cmd_count++;
            last_addr = a;
            last_hi   = hi_cnt;
            hi_cnt    = 0;
            resp_q.push_back('{cyc + lat, mem_word(a)});
            stall_left = stall_cfg;
        end else if (rd && stall_left > 0) begin
            stall_left--;
        end
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
            r = resp_q.pop_front();
            avm_readdatavalid = 1'b1;
            avm_readdata      = r.d;
            outstanding--;
        end
    end

    // Response monitor / scoreboard
    logic [31:0] exp_q[$];
    int          ready_count = 0;

    always @(negedge clk) begin
        if (rv_ready) begin
            ready_count++;
            if (exp_q.size() == 0) check("unexpected_ready", 32'd1, 32'd0);
            else                   check("rdata", rv_rdata, exp_q.pop_front());
        end
    end

    task automatic do_read(input logic [ADDR_W-1:0] addr, input logic [31:0] exp,
                           input logic flush, output int lat_rdy, output int lat_rd);
        @(negedge clk);
        rv_addr  = addr;
        rv_valid = 1'b1;
        pf_flush = flush;
        exp_q.push_back(exp);
        lat_rdy = -1;
        lat_rd  = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            pf_flush = 1'b0;
            if (lat_rd < 0 && avm_read) lat_rd = i;
            if (rv_ready) begin
                lat_rdy = i;
                break;
            end
        end
        rv_valid = 1'b0;
        if (lat_rdy < 0) begin
            check("ready_timeout", 32'd0, 32'd1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lr, la, c0, rc;
        rst_n    = 1'b0;
        rv_valid = 1'b0;
        rv_addr  = '0;
        pf_flush = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rv_ready", 32'(rv_ready), 32'd0);
        check("rst_avm_read", 32'(avm_read), 32'd0);
        check("rst_avm_address", 32'(avm_address), 32'd0);
        check("rst_rv_rdata", rv_rdata, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Miss, zero wait
        c0 = cmd_count;
        do_read(18'h00100, 32'hCAFE0001, 1'b0, lr, la);
        check("miss_cmd_addr", 32'(last_addr), 32'h040);
        check("miss_read_lat", 32'(la), 32'd1);
        check("miss_cmds", 32'(cmd_count - c0), 32'd1);
        repeat (10) @(negedge clk);
        check("pf_addr", 32'(last_addr), 32'h041);

        // Sequential hit
        c0 = cmd_count;
        do_read(18'h00104, 32'h12345678, 1'b0, lr, la);
        check("hit_ready_lat", 32'(lr), 32'd1);
        check("hit_no_cmd", 32'(cmd_count - c0), 32'd0);
        repeat (10) @(negedge clk);

        // Stall for five cycles
        stall_left = 5;
        unstable   = 0;
        c0         = cmd_count;
        do_read(18'h02000, mem_word(16'h0800), 1'b0, lr, la);
        check("stall_hi_cycles", 32'(last_hi), 32'd6);
        check("stall_stable", 32'(unstable), 32'd0);
        check("stall_one_cmd", 32'(cmd_count - c0), 32'd1);
        check("stall_addr", 32'(last_addr), 32'h800);
        repeat (10) @(negedge clk);

        // Wrap of the prefetch address, then flush forces a miss
        do_read(18'h3FFFC, mem_word(16'hFFFF), 1'b0, lr, la);
        repeat (10) @(negedge clk);
        check("wrap_pf_addr", 32'(last_addr), 32'h000);
        c0 = cmd_count;
        do_read(18'h00000, mem_word(16'h0000), 1'b1, lr, la);
        check("flush_miss_cmd", 32'(cmd_count - c0), 32'd1);
        check("flush_read_lat", 32'(la), 32'd1);
        check("flush_addr", 32'(last_addr), 32'h000);
        repeat (10) @(negedge clk);

        // Request at a different address while the prefetch is in flight
        do_read(18'h00300, mem_word(16'h00C0), 1'b0, lr, la);
        c0 = cmd_count;
        rc = ready_count;
        do_read(18'h00200, mem_word(16'h0080), 1'b0, lr, la);
        check("pfbusy_cmds", 32'(cmd_count - c0), 32'd2);
        check("pfbusy_addr", 32'(last_addr), 32'h080);
        check("pfbusy_one_ready", 32'(ready_count - rc), 32'd1);
        repeat (10) @(negedge clk);

        // Request matching the in-flight prefetch hits once it lands
        do_read(18'h00400, mem_word(16'h0100), 1'b0, lr, la);
        c0 = cmd_count;
        do_read(18'h00404, mem_word(16'h0101), 1'b0, lr, la);
        check("pfmatch_cmds", 32'(cmd_count - c0), 32'd1);
        check("pfmatch_addr", 32'(last_addr), 32'h101);
        repeat (10) @(negedge clk);

        // Request withdrawn during DWAIT: read completes, no response
        c0 = cmd_count;
        rc = ready_count;
        @(negedge clk);
        rv_addr  = 18'h08000;
        rv_valid = 1'b1;
        repeat (3) @(negedge clk);
        rv_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_no_ready", 32'(ready_count - rc), 32'd0);
        check("abort_one_cmd", 32'(cmd_count - c0), 32'd1);
        check("abort_idle_read", 32'(avm_read), 32'd0);

        // Reset in DWAIT, late response ignored
        rc = ready_count;
        @(negedge clk);
        rv_addr  = 18'h01000;
        rv_valid = 1'b1;
        repeat (3) @(negedge clk);
        rst_n    = 1'b0;
        rv_valid = 1'b0;
        #1;
        check("mid_rst_rv_ready", 32'(rv_ready), 32'd0);
        check("mid_rst_avm_read", 32'(avm_read), 32'd0);
        check("mid_rst_avm_address", 32'(avm_address), 32'd0);
        check("mid_rst_rv_rdata", rv_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("late_rdv_no_ready", 32'(ready_count - rc), 32'd0);
        check("late_rdv_rdata", rv_rdata, 32'd0);
        check("late_rdv_outstanding", 32'(outstanding), 32'd0);

        // Buffer was invalidated by reset: former prefetch word now misses
        c0 = cmd_count;
        do_read(18'h00408, mem_word(16'h0102), 1'b0, lr, la);
        check("post_rst_miss", 32'(cmd_count - c0), 32'd1);
        repeat (10) @(negedge clk);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/avs_read_bridge.md
AVS_READ_BRIDGE -- requirements
Module: avs_read_bridge

Interface
REQ-001 SHALL have parameter PREFETCH_EN, default 1, enabling the one-word next-address prefetch buffer.
REQ-002 SHALL have parameter ADDR_W, default 18, giving the byte-address width of the CPU-side port.
REQ-003 SHALL have port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port rv_valid  input  1  CPU-side read request; held with rv_addr until rv_ready.
REQ-006 SHALL have port rv_ready  output  1  one-cycle pulse marking rv_rdata valid.
REQ-007 SHALL have port rv_addr  input  ADDR_W  byte address; bits [1:0] are ignored.
REQ-008 SHALL have port rv_rdata  output  32  read data.
REQ-009 SHALL have port pf_flush  input  1  invalidates the prefetch buffer.
REQ-010 SHALL have port avm_address  output  ADDR_W-2  Avalon-MM word address.
REQ-011 SHALL have port avm_read  output  1  Avalon-MM read command.
REQ-012 SHALL have port avm_waitrequest  input  1  slave stall; command is accepted when avm_read=1 and avm_waitrequest=0.
REQ-013 SHALL have ports avm_readdata (input, 32) and avm_readdatavalid (input, 1) carrying the pipelined read response.

Function
REQ-014 SHALL use states IDLE, DREQ, DWAIT, RESP, PFREQ and PFWAIT.
REQ-015 IDLE with rv_valid and a buffer hit (buffer valid, tag == rv_addr[ADDR_W-1:2], pf_flush=0) SHALL go to RESP, giving rv_ready exactly 1 cycle after rv_valid rises.
REQ-016 IDLE with rv_valid and a miss SHALL go to DREQ; avm_read=1 and avm_address=rv_addr[ADDR_W-1:2] are registered, so avm_read appears 1 cycle after rv_valid.
REQ-017 In DREQ, avm_read and avm_address SHALL stay stable until avm_waitrequest=0, then the block goes to DWAIT with avm_read=0.
REQ-018 In DWAIT, avm_readdatavalid SHALL latch avm_readdata into rv_rdata and move to RESP.
REQ-019 RESP SHALL assert rv_ready for exactly one cycle.
REQ-020 After RESP, if PREFETCH_EN=1, the block SHALL go to PFREQ for word tag+1, which wraps from all-ones to 0. Otherwise it SHALL go to IDLE.
REQ-021 PFREQ and PFWAIT SHALL behave like DREQ and DWAIT, but write the data into the buffer, set buffer valid, and then go to IDLE.
REQ-022 An rv_valid arriving during PFREQ or PFWAIT SHALL wait; the prefetch always completes, because an Avalon read cannot be aborted. The block then evaluates the request as in IDLE, so a matching address hits.
REQ-023 If rv_valid drops during DREQ or DWAIT, the Avalon read SHALL complete, the data SHALL be discarded, no rv_ready is issued, and the block returns to IDLE.
REQ-024 pf_flush SHALL clear buffer valid in the same cycle. pf_flush together with a hit SHALL be treated as a miss. pf_flush during PFWAIT SHALL cause the returning data to be discarded.
REQ-025 rv_rdata SHALL hold its last value between responses.
REQ-026 At most one Avalon read SHALL be outstanding at any time.

Reset
REQ-027 Asserting rst_n low SHALL force state=IDLE, rv_ready=0, avm_read=0, avm_address=0, rv_rdata=0, buffer valid=0 and buffer tag=0, at any point in operation.
REQ-028 After deassertion, avm_readdatavalid from a read issued before reset SHALL be ignored while the block is in IDLE.

Structure
REQ-029 The state enumeration and the ADDR_W default SHALL live in a shared package avs_bridge_pkg.
REQ-030 The prefetch buffer (tag, data, valid, hit compare) SHALL be the sub-module avs_pf_buffer. Everything else SHALL be one FSM.

Verification
REQ-031 Miss, zero wait: rv_valid, addr 0x00100, waitrequest=0, readdatavalid 2 cycles later with 0xCAFE0001 -> avm_address=0x040, rv_ready pulses once with 0xCAFE0001.
REQ-032 Sequential hit: after REQ-031 the prefetch of 0x041 returns 0x12345678; then rv_valid at 0x00104 -> rv_ready 1 cycle later with 0x12345678 and no new avm_read.
REQ-033 Stall: waitrequest held high for 5 cycles -> avm_read and avm_address stay stable for all 6 cycles, then exactly one command is accepted.
REQ-034 Wrap and flush: a read at 0x3FFFC prefetches word 0x0000. pf_flush asserted with rv_valid at 0x00000 -> miss, and a new avm_read is issued.
REQ-035 Request during prefetch at a different address: rv_valid at 0x00200 while PFWAIT is pending -> prefetch completes first, then avm_address=0x080, and rv_ready pulses once.
REQ-036 Reset mid-DWAIT: rst_n low for 1 cycle -> all outputs are 0, and a late readdatavalid produces no rv_ready.
